// File: rtl/rv_pkg.sv
// Shared RISC-V core types and defaults used by the integer register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv_pkg;

    localparam int XLEN_DEFAULT     = 32;
    localparam int NUM_REGS_DEFAULT = 32;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] xlen_t;

    // x0 is hardwired to zero in the architecture.
    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/register_file_sb_if.sv
// Bundle of decode/writeback-facing signals for the scoreboarded register file.
// Latency: n/a (wires only); reads are combinational through the slave.
// Backpressure: none; every strobe is accepted on the edge it is presented.
interface register_file_sb_if #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_READ = 2
);
    localparam int AW = $clog2(NUM_REGS);

    // Read side (decode)
    logic [NUM_READ*AW-1:0]   rd_addr;
    logic [NUM_READ*XLEN-1:0] rd_data;
    logic [NUM_READ-1:0]      rd_busy;

    // Write side (writeback)
    logic                     wr_en;
    logic [AW-1:0]            wr_addr;
    logic [XLEN-1:0]          wr_data;

    // Scoreboard side (issue of long-latency ops)
    logic                     busy_set;
    logic [AW-1:0]            busy_addr;
    logic                     any_busy;

    // Statistics
    logic [31:0]              wr_count;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, busy_set, busy_addr,
        input  rd_data, rd_busy, any_busy, wr_count
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, busy_set, busy_addr,
        output rd_data, rd_busy, any_busy, wr_count
    );

endinterface

// File: rtl/register_file_sb_read_port.sv
// One combinational read port: stored value/busy, with optional same-cycle write forwarding.
// Latency: zero cycles (pure combinational lookup).
// Backpressure: none; always presents data for the current address.
module regfile_read_port #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic [NUM_REGS-1:0][XLEN-1:0] regs,
    input  logic [NUM_REGS-1:0]           busy,
    input  logic [AW-1:0]                 rd_addr,
    // wr_en/busy_set arrive already qualified: non-zero address, not in reset
    input  logic                          wr_en,
    input  logic [AW-1:0]                 wr_addr,
    input  logic [XLEN-1:0]               wr_data,
    input  logic                          busy_set,
    input  logic [AW-1:0]                 busy_addr,
    output logic [XLEN-1:0]               rd_data,
    output logic                          rd_busy
);

    logic hit;

    // Select forwarded write data or the stored entry; x0 reads rely on regs[0]/busy[0] being zero.
    always_comb begin
        hit     = (BYPASS != 0) && wr_en && (wr_addr == rd_addr) && (rd_addr != '0);
        rd_data = regs[rd_addr];
        rd_busy = busy[rd_addr];
        if (hit) begin
            rd_data = wr_data;
            // The write retires the old producer unless a new one is issued on the same edge.
            rd_busy = busy_set && (busy_addr == rd_addr);
        end
    end

endmodule

// File: rtl/register_file_sb.sv
// Clocked integer register file with per-register busy scoreboard and write counter.
// Latency: reads zero-cycle combinational; writes and busy updates take effect on the next clk edge.
// Backpressure: none; writes and busy_set are always accepted, x0 targets are dropped.
module register_file_sb
    import rv_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NUM_REGS = NUM_REGS_DEFAULT,
    parameter int NUM_READ = 2,
    parameter int BYPASS   = 1
) (
    input  logic               clk,
    input  logic               reset,
    register_file_sb_if.slave  rf
);

    localparam int AW = $clog2(NUM_REGS);
    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic [NUM_REGS-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]           busy_q, busy_d;
    logic [31:0]                   wr_count_q, wr_count_d;

    logic                          wr_fire;
    logic                          set_fire;

    logic [NUM_READ-1:0][XLEN-1:0] rd_data_w;
    logic [NUM_READ-1:0]           rd_busy_w;

    // Qualified strobes: x0 targets are dropped, and nothing forwards while reset is held.
    always_comb begin
        wr_fire  = rf.wr_en    && !reset && (rf.wr_addr   != ZERO_ADDR);
        set_fire = rf.busy_set && !reset && (rf.busy_addr != ZERO_ADDR);
    end

    // Next-state for storage, scoreboard and counter; busy_set is applied after the
    // write-clear so a newly issued producer wins over the retiring one.
    always_comb begin
        regs_d     = regs_q;
        busy_d     = busy_q;
        wr_count_d = wr_count_q;
        if (wr_fire) begin
            regs_d[rf.wr_addr] = rf.wr_data;
            busy_d[rf.wr_addr] = 1'b0;
            wr_count_d         = wr_count_q + 32'd1;
        end
        if (set_fire) begin
            busy_d[rf.busy_addr] = 1'b1;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    // State registers, cleared asynchronously so outputs drop to zero the moment reset rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q     <= '0;
            busy_q     <= '0;
            wr_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            wr_count_q <= wr_count_d;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        regfile_read_port #(
            .XLEN     (XLEN),
            .NUM_REGS (NUM_REGS),
            .BYPASS   (BYPASS)
        ) u_rd_port (
            .regs      (regs_q),
            .busy      (busy_q),
            .rd_addr   (rf.rd_addr[i*AW +: AW]),
            .wr_en     (wr_fire),
            .wr_addr   (rf.wr_addr),
            .wr_data   (rf.wr_data),
            .busy_set  (set_fire),
            .busy_addr (rf.busy_addr),
            .rd_data   (rd_data_w[i]),
            .rd_busy   (rd_busy_w[i])
        );
    end

    assign rf.rd_data  = rd_data_w;
    assign rf.rd_busy  = rd_busy_w;
    assign rf.any_busy = |busy_q;
    assign rf.wr_count = wr_count_q;

endmodule
